cpu_control_unit: RTL and testbench
===================================

# cpu_control_unit

Microcoded sequencer for the 8-bit bus CPU. It owns the instruction step counter and drives every bus-enable and register-load strobe (the control word) from the current step, the IR opcode and the ALU flags. It sits between the instruction register/flag register and the datapath registers, advancing only on the divided CPU tick. Fetch, execute, early instruction termination and halt are all handled here.

## Interface
- `EARLY_END`, default 1: 1 = step counter returns to T0 after an instruction's last active step; 0 = every instruction runs T0..T5.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `step_en`  in  1  CPU tick (one `clk` cycle wide); state advances only when high.
- `opcode`  in  4  IR[7:4]; valid from T2 onward.
- `flag_c`  in  1  registered ALU carry.
- `flag_z`  in  1  registered ALU zero.
- `ctrl`  out  16  control word (bit map below).
- `step`  out  3  current T-state (0..5).
- `instr_done`  out  1  high during the final step of the current instruction.
- `halted`  out  1  sticky halt status.

## Operation
- `ctrl` bits: 0 pc_out, 1 pc_add, 2 pc_load, 3 mar_in, 4 ram_in (RAM write), 5 ram_out, 6 ir_in, 7 ir_out, 8 a_in, 9 a_out, 10 b_in, 11 alu_out, 12 alu_sub, 13 flags_in, 14 output_in, 15 hlt.
- Fetch, same for all opcodes:
  - T0: pc_out|mar_in (0x0009).
  - T1: ram_out|ir_in|pc_add (0x0062).
- Execute, from T2:
  - 0x0 NOP: T2 = 0, last step T2.
  - 0x1 LDA: T2 ir_out|mar_in; T3 ram_out|a_in.
  - 0x2 ADD: T2 ir_out|mar_in; T3 ram_out|b_in; T4 alu_out|a_in|flags_in.
  - 0x3 OUT: T2 a_out|output_in.
  - 0x4 SUB: as ADD, plus alu_sub in T4.
  - 0x5 STA: T2 ir_out|mar_in; T3 a_out|ram_in.
  - 0x6 LDI: T2 ir_out|a_in.
  - 0x7 JMP: T2 ir_out|pc_load.
  - 0x8 JC: T2 ir_out|pc_load only if `flag_c`, else 0.
  - 0x9 JZ: as JC, using `flag_z`.
  - 0xF HLT: T2 hlt.
  - 0xA..0xE: treated as NOP.
- Step counter:
  - On `step_en`, step increments.
  - If `instr_done`, step goes to 0 instead (EARLY_END=1).
  - With EARLY_END=0, wrap occurs only from T5; steps after the last active step output ctrl=0, and `instr_done` is high only in T5.
- Halt:
  - `step_en` while ctrl[15]=1 sets `halted` and forces step to 0.
  - While halted: ctrl=0, step frozen, `step_en` ignored, `instr_done`=0. Cleared only by reset.

## Timing
- `ctrl` and `instr_done` are combinational from `step`, `opcode`, flags and `halted`. They are stable for the whole step; the datapath samples them at the `step_en` edge.
- `step` and `halted` are registered and change only on `clk` rising edges where `step_en`=1.
- Flags are sampled combinationally in T2 of JC/JZ. A flag change mid-step changes pc_load in the same cycle; the value at the `step_en` edge is the one that counts.
- Reset, asynchronous: step=0, halted=0. Outputs during and after reset: ctrl=0x0009, instr_done=0.
- Reset mid-instruction aborts it immediately; the next tick executes T1 of a fresh fetch.
- Instruction lengths in ticks (EARLY_END=1): NOP/OUT/LDI/JMP/JC/JZ/HLT 3, LDA/STA 4, ADD/SUB 5. With EARLY_END=0, all take 6.
- `step_en` held high continuously is legal: one step per `clk`.

## Configuration
- `CTRL_COND_JUMP_EN` defined: JC (0x8) and JZ (0x9) are decoded as above.
- Not defined: 0x8 and 0x9 decode as NOP, `flag_c`/`flag_z` are unused, and flag logic is removed.

## Test plan
- Reset: assert `rst_n`=0 mid-T3 of ADD -> step=0, ctrl=0x0009, halted=0 immediately. After release, the first tick moves to T1 with ctrl=0x0062.
- ADD, EARLY_END=1, opcode=0x2: ticks produce ctrl 0x0009, 0x0062, 0x0088, 0x0420, 0x2900. `instr_done` is high only in T4; the next tick gives step=0.
- JC with `CTRL_COND_JUMP_EN`, opcode=0x8:
  - flag_c=1 -> T2 ctrl=0x0084, done at T2.
  - flag_c=0 -> T2 ctrl=0x0000, done at T2.
- HLT, opcode=0xF: T2 ctrl=0x8000. After that tick, halted=1, ctrl=0, step=0; 10 further `step_en` pulses leave all outputs unchanged.
- Stall: `step_en`=0 for 20 clks in T3 of LDA -> step=3 and ctrl=0x0120 held. One pulse then returns step to 0.
- EARLY_END=0, opcode=0x3: T2 ctrl=0x4200, T3..T5 ctrl=0, `instr_done` only in T5. Without the macro, opcode=0x9 gives T2 ctrl=0 regardless of flag_z.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Microcoded sequencer for the 8-bit bus CPU: step counter, control-word decode and halt.
// Optional macro CTRL_COND_JUMP_EN enables the JC/JZ conditional jumps.
module cpu_control_unit #(
    parameter int EARLY_END = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_en,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        instr_done,
    output logic        halted
);

    localparam logic [15:0] PC_OUT    = 16'h0001;
    localparam logic [15:0] PC_ADD    = 16'h0002;
    localparam logic [15:0] PC_LOAD   = 16'h0004;
    localparam logic [15:0] MAR_IN    = 16'h0008;
    localparam logic [15:0] RAM_IN    = 16'h0010;
    localparam logic [15:0] RAM_OUT   = 16'h0020;
    localparam logic [15:0] IR_IN     = 16'h0040;
    localparam logic [15:0] IR_OUT    = 16'h0080;
    localparam logic [15:0] A_IN      = 16'h0100;
    localparam logic [15:0] A_OUT     = 16'h0200;
    localparam logic [15:0] B_IN      = 16'h0400;
    localparam logic [15:0] ALU_OUT   = 16'h0800;
    localparam logic [15:0] ALU_SUB   = 16'h1000;
    localparam logic [15:0] FLAGS_IN  = 16'h2000;
    localparam logic [15:0] OUTPUT_IN = 16'h4000;
    localparam logic [15:0] HLT       = 16'h8000;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_OUT = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} step_t;

    step_t       state;
    step_t       last_step;
    step_t       final_step;
    logic [15:0] exec_ctrl;

    // Execute-phase microcode; only consulted from T2 onward.
    always_comb begin
        exec_ctrl = '0;
        last_step = T2;
        case (opcode)
            OP_LDA: begin
                last_step = T3;
                case (state)
                    T2:      exec_ctrl = IR_OUT | MAR_IN;
                    T3:      exec_ctrl = RAM_OUT | A_IN;
                    default: exec_ctrl = '0;
                endcase
            end
            OP_ADD, OP_SUB: begin
                last_step = T4;
                case (state)
                    T2:      exec_ctrl = IR_OUT | MAR_IN;
                    T3:      exec_ctrl = RAM_OUT | B_IN;
                    T4:      exec_ctrl = ALU_OUT | A_IN | FLAGS_IN
                                       | ((opcode == OP_SUB) ? ALU_SUB : 16'h0000);
                    default: exec_ctrl = '0;
                endcase
            end
            OP_STA: begin
                last_step = T3;
                case (state)
                    T2:      exec_ctrl = IR_OUT | MAR_IN;
                    T3:      exec_ctrl = A_OUT | RAM_IN;
                    default: exec_ctrl = '0;
                endcase
            end
            OP_OUT: if (state == T2) exec_ctrl = A_OUT | OUTPUT_IN;
            OP_LDI: if (state == T2) exec_ctrl = IR_OUT | A_IN;
            OP_JMP: if (state == T2) exec_ctrl = IR_OUT | PC_LOAD;
`ifdef CTRL_COND_JUMP_EN
            OP_JC:  if (state == T2 && flag_c) exec_ctrl = IR_OUT | PC_LOAD;
            OP_JZ:  if (state == T2 && flag_z) exec_ctrl = IR_OUT | PC_LOAD;
`endif
            OP_HLT: if (state == T2) exec_ctrl = HLT;
            default: exec_ctrl = '0;
        endcase
    end

`ifndef CTRL_COND_JUMP_EN
    logic unused_flags;
    assign unused_flags = flag_c | flag_z;
`endif

    always_comb begin
        if (halted) begin
            ctrl = '0;
        end else begin
            case (state)
                T0:      ctrl = PC_OUT | MAR_IN;
                T1:      ctrl = RAM_OUT | IR_IN | PC_ADD;
                default: ctrl = exec_ctrl;
            endcase
        end
    end

    assign final_step = (EARLY_END != 0) ? last_step : T5;
    assign instr_done = !halted && (state == final_step);
    assign step       = state;

    // Step counter and sticky halt; everything frozen once halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= T0;
            halted <= 1'b0;
        end else if (step_en && !halted) begin
            if (ctrl[15]) begin
                halted <= 1'b1;
                state  <= T0;
            end else if (instr_done) begin
                state <= T0;
            end else begin
                state <= step_t'(state + 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: table-driven instruction vectors on an
// EARLY_END=1 and an EARLY_END=0 instance, plus reset, stall, halt and flag sequences.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        step_en1, step_en6;
    logic [3:0]  opcode;
    logic        flag_c, flag_z;
    logic [15:0] ctrl1, ctrl6;
    logic [2:0]  step1, step6;
    logic        done1, done6, halted1, halted6;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_control_unit #(.EARLY_END(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .step_en(step_en1), .opcode(opcode),
        .flag_c(flag_c), .flag_z(flag_z), .ctrl(ctrl1), .step(step1),
        .instr_done(done1), .halted(halted1)
    );

    cpu_control_unit #(.EARLY_END(0)) dut6 (
        .clk(clk), .rst_n(rst_n), .step_en(step_en6), .opcode(opcode),
        .flag_c(flag_c), .flag_z(flag_z), .ctrl(ctrl6), .step(step6),
        .instr_done(done6), .halted(halted6)
    );

    typedef struct {
        logic [3:0]  op;
        logic        fc;
        logic        fz;
        int          len;
        logic [15:0] c2;
        logic [15:0] c3;
        logic [15:0] c4;
    } vec_t;

    vec_t tbl[20];
    int   ntbl = 0;

    task automatic add(input logic [3:0] op, input logic fc, input logic fz, input int len,
                       input logic [15:0] c2, input logic [15:0] c3, input logic [15:0] c4);
        tbl[ntbl].op = op; tbl[ntbl].fc = fc; tbl[ntbl].fz = fz; tbl[ntbl].len = len;
        tbl[ntbl].c2 = c2; tbl[ntbl].c3 = c3; tbl[ntbl].c4 = c4;
        ntbl++;
    endtask

    function automatic logic [15:0] exp_ctrl(input vec_t v, input int s);
        if (s == 0) return 16'h0009;
        if (s == 1) return 16'h0062;
        if (s >= v.len) return 16'h0000;
        if (s == 2) return v.c2;
        if (s == 3) return v.c3;
        return v.c4;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
        end
    endtask

    // Called at negedge+1; one posedge with step_en high, returns at next negedge+1.
    task automatic pulse1();
        step_en1 = 1'b1;
        @(negedge clk);
        step_en1 = 1'b0;
        #1;
    endtask

    task automatic pulse6();
        step_en6 = 1'b1;
        @(negedge clk);
        step_en6 = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic run_vec(input vec_t v, input bit long_mode);
        int L;
        L = long_mode ? 6 : v.len;
        opcode = v.op;
        flag_c = v.fc;
        flag_z = v.fz;
        #1;
        for (int s = 0; s < L; s++) begin
            if (long_mode) begin
                check($sformatf("ee0 op%0h T%0d step", v.op, s), {13'd0, step6}, 16'(s));
                check($sformatf("ee0 op%0h T%0d ctrl", v.op, s), ctrl6, exp_ctrl(v, s));
                check($sformatf("ee0 op%0h T%0d done", v.op, s), {15'd0, done6}, {15'd0, s == L - 1});
                pulse6();
            end else begin
                check($sformatf("ee1 op%0h T%0d step", v.op, s), {13'd0, step1}, 16'(s));
                check($sformatf("ee1 op%0h T%0d ctrl", v.op, s), ctrl1, exp_ctrl(v, s));
                check($sformatf("ee1 op%0h T%0d done", v.op, s), {15'd0, done1}, {15'd0, s == L - 1});
                pulse1();
            end
        end
        if (long_mode) check($sformatf("ee0 op%0h wrap", v.op), {13'd0, step6}, 16'd0);
        else           check($sformatf("ee1 op%0h wrap", v.op), {13'd0, step1}, 16'd0);
    endtask

    initial begin
        add(4'h0, 0, 0, 3, 16'h0000, 16'h0000, 16'h0000);
        add(4'h1, 0, 0, 4, 16'h0088, 16'h0120, 16'h0000);
        add(4'h2, 0, 0, 5, 16'h0088, 16'h0420, 16'h2900);
        add(4'h3, 0, 0, 3, 16'h4200, 16'h0000, 16'h0000);
        add(4'h4, 0, 0, 5, 16'h0088, 16'h0420, 16'h3900);
        add(4'h5, 0, 0, 4, 16'h0088, 16'h0210, 16'h0000);
        add(4'h6, 0, 0, 3, 16'h0180, 16'h0000, 16'h0000);
        add(4'h7, 0, 0, 3, 16'h0084, 16'h0000, 16'h0000);
`ifdef CTRL_COND_JUMP_EN
        add(4'h8, 1, 0, 3, 16'h0084, 16'h0000, 16'h0000);
        add(4'h8, 0, 1, 3, 16'h0000, 16'h0000, 16'h0000);
        add(4'h9, 0, 1, 3, 16'h0084, 16'h0000, 16'h0000);
        add(4'h9, 1, 0, 3, 16'h0000, 16'h0000, 16'h0000);
`else
        add(4'h8, 1, 1, 3, 16'h0000, 16'h0000, 16'h0000);
        add(4'h9, 1, 1, 3, 16'h0000, 16'h0000, 16'h0000);
        add(4'h9, 0, 0, 3, 16'h0000, 16'h0000, 16'h0000);
`endif
        add(4'hA, 0, 0, 3, 16'h0000, 16'h0000, 16'h0000);
        add(4'hE, 1, 1, 3, 16'h0000, 16'h0000, 16'h0000);

        rst_n = 1'b0; step_en1 = 1'b0; step_en6 = 1'b0;
        opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset step", {13'd0, step1}, 16'd0);
        check("reset ctrl", ctrl1, 16'h0009);
        check("reset done", {15'd0, done1}, 16'd0);
        check("reset halted", {15'd0, halted1}, 16'd0);
        check("reset ctrl ee0", ctrl6, 16'h0009);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < ntbl; i++) run_vec(tbl[i], 1'b0);
        for (int i = 0; i < ntbl; i++) run_vec(tbl[i], 1'b1);

        // Asynchronous reset in T3 of ADD.
        opcode = 4'h2;
        repeat (3) pulse1();
        check("add pre-reset step", {13'd0, step1}, 16'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset step", {13'd0, step1}, 16'd0);
        check("async reset ctrl", ctrl1, 16'h0009);
        check("async reset halted", {15'd0, halted1}, 16'd0);
        check("async reset done", {15'd0, done1}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        pulse1();
        check("post-reset step", {13'd0, step1}, 16'd1);
        check("post-reset ctrl", ctrl1, 16'h0062);
        do_reset();

        // step_en held high: one step per clock.
        opcode = 4'h1;
        step_en1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("continuous step %0d", k), {13'd0, step1}, 16'((k + 1) % 4));
        end
        step_en1 = 1'b0;
        do_reset();

        // Stall in T3 of LDA.
        opcode = 4'h1;
        repeat (3) pulse1();
        repeat (20) @(negedge clk);
        #1;
        check("stall step", {13'd0, step1}, 16'd3);
        check("stall ctrl", ctrl1, 16'h0120);
        pulse1();
        check("stall resume step", {13'd0, step1}, 16'd0);

        // Halt and sticky behaviour.
        opcode = 4'hF;
        repeat (2) pulse1();
        check("hlt T2 ctrl", ctrl1, 16'h8000);
        check("hlt T2 done", {15'd0, done1}, 16'd1);
        pulse1();
        for (int k = 0; k < 11; k++) begin
            check($sformatf("halted flag %0d", k), {15'd0, halted1}, 16'd1);
            check($sformatf("halted ctrl %0d", k), ctrl1, 16'h0000);
            check($sformatf("halted step %0d", k), {13'd0, step1}, 16'd0);
            check($sformatf("halted done %0d", k), {15'd0, done1}, 16'd0);
            pulse1();
        end
        do_reset();
        check("halt cleared", {15'd0, halted1}, 16'd0);
        check("halt cleared ctrl", ctrl1, 16'h0009);

`ifdef CTRL_COND_JUMP_EN
        // Flag change mid-step alters pc_load combinationally.
        opcode = 4'h8;
        flag_c = 1'b0;
        repeat (2) pulse1();
        check("jc flag low ctrl", ctrl1, 16'h0000);
        flag_c = 1'b1;
        #1;
        check("jc flag rise ctrl", ctrl1, 16'h0084);
        pulse1();
        check("jc end step", {13'd0, step1}, 16'd0);
        flag_c = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
